aes_round_ctrl: RTL and testbench

- Parametrised AES control FSM that replaces the fixed AES-128 sequencer. Supports 128-, 192- and 256-bit keys (Nr = 10/12/14) and both encrypt and decrypt.
- Sequences the key-schedule write pass and drives round-key indices and datapath strobes for the initial AddRoundKey, the middle rounds and the final round.
- Adds a start/ready input handshake and an out_valid/out_ready output handshake with backpressure.
- Sits between the top-level wrapper and the round-key store / round datapath.

---
 rtl/aes_ctrl_pkg.sv | 38 +++
 rtl/aes_rk_index.sv | 25 ++
 rtl/aes_round_ctrl.sv | 155 +++++++++++++++
 tb/tb_aes_round_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/aes_ctrl_pkg.sv
// Shared types and helpers for the AES round controller.
// Round count lookup keeps the key-length decoding in one place.
package aes_ctrl_pkg;

    localparam int MAX_NR_C = 14;

    typedef enum logic [2:0] {
        IDLE,
        KEXP,
        INIT_ARK,
        ROUND,
        FINAL,
        OUT_WAIT
    } ctrl_state_t;

    typedef enum logic [1:0] {
        K128 = 2'd0,
        K192 = 2'd1,
        K256 = 2'd2
    } klen_t;

    // Which datapath operation is reading the round-key store this cycle
    typedef enum logic [1:0] {
        PH_NONE,
        PH_INIT,
        PH_ROUND,
        PH_FINAL
    } rk_phase_t;

    function automatic logic [7:0] nr_of(klen_t k);
        case (k)
            K192:    return 8'd12;
            K256:    return 8'd14;
            default: return 8'd10;
        endcase
    endfunction

endpackage

// File: rtl/aes_rk_index.sv
// Round-key read index generator: forward order for encrypt,
// reversed order (Nr down to 0) for decrypt.
module aes_rk_index
    import aes_ctrl_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic             enc,
    input  logic [IDX_W-1:0] cnt,
    input  logic [IDX_W-1:0] nr,
    input  rk_phase_t        phase,
    output logic [IDX_W-1:0] rd_idx
);

    always_comb begin
        rd_idx = '0;
        case (phase)
            PH_INIT:  rd_idx = enc ? '0  : nr;
            PH_ROUND: rd_idx = enc ? cnt : nr - cnt;
            PH_FINAL: rd_idx = enc ? nr  : '0;
            default:  rd_idx = '0;
        endcase
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// AES control FSM for 128/192/256-bit keys: key-schedule write pass,
// round sequencing for encrypt/decrypt, and start/ready + out_valid/out_ready handshakes.
module aes_round_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int         MAX_NR   = 14,
    parameter int         IDX_W    = $clog2(MAX_NR + 1),
    parameter logic [2:0] LEN_MASK = 3'b111
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_load,
    input  logic [1:0]       key_len,
    input  logic             start,
    input  logic             encrypt,
    output logic             ready,
    output logic             key_valid,
    output logic             busy,
    output logic             kexp_step,
    output logic             rk_we,
    output logic [IDX_W-1:0] rk_wr_idx,
    output logic [IDX_W-1:0] rk_rd_idx,
    output logic             dp_load,
    output logic             dp_round,
    output logic             dp_final,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             done,
    output logic             err
);

    ctrl_state_t      state, state_nxt;
    logic [IDX_W-1:0] cnt, cnt_nxt;
    logic [IDX_W-1:0] nr, nr_nxt;
    logic             enc, enc_nxt;
    logic             kv_nxt;
    rk_phase_t        phase;
    logic             len_ok;
    logic [3:0]       mask_ext;

    // Code 3 maps to the always-zero top bit, so reserved lengths are rejected
    assign mask_ext = {1'b0, LEN_MASK};
    assign len_ok   = mask_ext[key_len];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            nr        <= '0;
            enc       <= 1'b0;
            key_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            nr        <= nr_nxt;
            enc       <= enc_nxt;
            key_valid <= kv_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        nr_nxt    = nr;
        enc_nxt   = enc;
        kv_nxt    = key_valid;
        phase     = PH_NONE;
        ready     = 1'b0;
        busy      = (state != IDLE);
        kexp_step = 1'b0;
        rk_we     = 1'b0;
        rk_wr_idx = '0;
        dp_load   = 1'b0;
        dp_round  = 1'b0;
        dp_final  = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        err       = 1'b0;

        case (state)
            IDLE: begin
                ready = key_valid & ~key_load;
                if (key_load) begin
                    if (len_ok) begin
                        nr_nxt    = IDX_W'(nr_of(klen_t'(key_len)));
                        kv_nxt    = 1'b0;
                        cnt_nxt   = '0;
                        state_nxt = KEXP;
                    end else begin
                        err = 1'b1;
                    end
                end else if (start) begin
                    if (key_valid) begin
                        enc_nxt   = encrypt;
                        state_nxt = INIT_ARK;
                    end else begin
                        err = 1'b1;
                    end
                end
            end
            KEXP: begin
                kexp_step = 1'b1;
                rk_we     = 1'b1;
                rk_wr_idx = cnt;
                if (cnt == nr) begin
                    kv_nxt    = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + IDX_W'(1);
                end
            end
            INIT_ARK: begin
                dp_load   = 1'b1;
                phase     = PH_INIT;
                cnt_nxt   = IDX_W'(1);
                state_nxt = ROUND;
            end
            ROUND: begin
                dp_round = 1'b1;
                phase    = PH_ROUND;
                // Last middle round reads index Nr-1 (or 1), so the counter stops short of Nr
                if (cnt == nr - IDX_W'(1)) begin
                    cnt_nxt   = '0;
                    state_nxt = FINAL;
                end else begin
                    cnt_nxt = cnt + IDX_W'(1);
                end
            end
            FINAL: begin
                dp_final  = 1'b1;
                phase     = PH_FINAL;
                state_nxt = OUT_WAIT;
            end
            OUT_WAIT: begin
                out_valid = 1'b1;
                done      = out_ready;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Requests while busy are dropped but flagged
        if (state != IDLE && (key_load || start)) err = 1'b1;
    end

    aes_rk_index #(.IDX_W(IDX_W)) u_rk_index (
        .enc    (enc),
        .cnt    (cnt),
        .nr     (nr),
        .phase  (phase),
        .rd_idx (rk_rd_idx)
    );

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Randomized bench for aes_round_ctrl: expected per-cycle output traces are
// generated from the round/key-schedule ordering rules and compared cycle by cycle.
module tb_aes_round_ctrl;
    import aes_ctrl_pkg::*;

    localparam int IDX_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             key_load, start, encrypt, out_ready;
    logic [1:0]       key_len;
    logic             ready, key_valid, busy, kexp_step, rk_we;
    logic [IDX_W-1:0] rk_wr_idx, rk_rd_idx;
    logic             dp_load, dp_round, dp_final, out_valid, done, err;

    int n_cmp = 0;
    int n_bad = 0;
    bit mkv;
    int mnr;

    always #5 clk = ~clk;

    aes_round_ctrl #(.MAX_NR(14), .IDX_W(IDX_W), .LEN_MASK(3'b111)) dut (
        .clk(clk), .reset(reset), .key_load(key_load), .key_len(key_len),
        .start(start), .encrypt(encrypt), .ready(ready), .key_valid(key_valid),
        .busy(busy), .kexp_step(kexp_step), .rk_we(rk_we), .rk_wr_idx(rk_wr_idx),
        .rk_rd_idx(rk_rd_idx), .dp_load(dp_load), .dp_round(dp_round),
        .dp_final(dp_final), .out_valid(out_valid), .out_ready(out_ready),
        .done(done), .err(err)
    );

    logic [18:0] obs;
    assign obs = {ready, key_valid, busy, kexp_step, rk_we, rk_wr_idx, rk_rd_idx,
                  dp_load, dp_round, dp_final, out_valid, done, err};

    function automatic logic [18:0] ev(bit rdy, bit kv, bit bsy, bit kx, bit we, int widx,
                                        int ridx, bit ld, bit rd, bit fn, bit ov, bit dn, bit er);
        logic [3:0] w, r;
        w = widx[3:0];
        r = ridx[3:0];
        return {rdy, kv, bsy, kx, we, w, r, ld, rd, fn, ov, dn, er};
    endfunction

    task automatic chk(input string tag, input logic [18:0] got, input logic [18:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [18:0] e);
        #1;
        chk(tag, obs, e);
        @(negedge clk);
    endtask

    task automatic quiet();
        key_load = 1'b0;
        start    = 1'b0;
    endtask

    task automatic poke(output bit er);
        key_load = ($urandom_range(0, 3) == 0);
        start    = ($urandom_range(0, 3) == 0);
        key_len  = 2'($urandom);
        encrypt  = 1'($urandom);
        er       = key_load | start;
    endtask

    task automatic keyload(input int len, input bit with_start);
        int nr;
        bit er;
        nr       = 10 + 2 * len;
        key_load = 1'b1;
        key_len  = 2'(len);
        start    = with_start;
        encrypt  = 1'($urandom);
        cyc("kl_req", ev(0, mkv, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        mkv = 0;
        mnr = nr;
        for (int i = 0; i <= nr; i++) begin
            poke(er);
            cyc($sformatf("kexp%0d", i), ev(0, 0, 1, 1, 1, i, 0, 0, 0, 0, 0, 0, er));
        end
        quiet();
        mkv = 1;
        cyc("kl_end", ev(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic block(input bit enc, input int bp, input int abort_at);
        int nr;
        bit er;
        nr        = mnr;
        out_ready = 1'b0;
        quiet();
        start   = 1'b1;
        encrypt = enc;
        cyc("blk_req", ev(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        poke(er);
        cyc("init", ev(0, 1, 1, 0, 0, 0, enc ? 0 : nr, 1, 0, 0, 0, 0, er));
        for (int r = 1; r < nr; r++) begin
            if (r == abort_at) begin
                quiet();
                reset = 1'b1;
                cyc("abort", ev(0, 1, 1, 0, 0, 0, enc ? r : nr - r, 0, 1, 0, 0, 0, 0));
                reset = 1'b0;
                mkv   = 0;
                cyc("post_rst", '0);
                return;
            end
            poke(er);
            cyc($sformatf("rnd%0d_e%0d", r, enc), ev(0, 1, 1, 0, 0, 0, enc ? r : nr - r, 0, 1, 0, 0, 0, er));
        end
        poke(er);
        cyc("final", ev(0, 1, 1, 0, 0, 0, enc ? nr : 0, 0, 0, 1, 0, 0, er));
        for (int i = 0; i < bp; i++) begin
            start    = 1'b1;
            key_load = 1'($urandom_range(0, 1));
            cyc($sformatf("hold%0d", i), ev(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
        end
        quiet();
        out_ready = 1'b1;
        cyc("done", ev(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        out_ready = 1'b0;
        cyc("idle_after", ev(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        reset     = 1'b1;
        key_load  = 1'b0;
        start     = 1'b0;
        encrypt   = 1'b0;
        key_len   = 2'd0;
        out_ready = 1'b0;
        mkv       = 0;
        mnr       = 10;
        @(negedge clk);
        cyc("rst", '0);
        reset = 1'b0;
        cyc("rst_rel", '0);

        start = 1'b1;
        cyc("nokey_start", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        quiet();
        cyc("nokey_idle", '0);
        key_load = 1'b1;
        key_len  = 2'd3;
        cyc("kl_rsv", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        quiet();
        cyc("kl_rsv_idle", '0);

        keyload(0, 0);
        block(1, 0, -1);
        keyload(2, 0);
        block(0, 0, -1);
        block(1, 5, -1);

        key_load = 1'b1;
        key_len  = 2'd3;
        cyc("kl_rsv_kv", ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        quiet();
        cyc("kl_rsv_kv_idle", ev(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        keyload(0, 1);
        block(1, 0, 3);
        keyload(1, 0);
        block(1, 0, -1);
        block(0, 2, -1);

        for (int it = 0; it < 20; it++) begin
            if ($urandom_range(0, 3) == 0) keyload($urandom_range(0, 2), 1'($urandom));
            block(1'($urandom), $urandom_range(0, 3), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
